// File: rtl/ps2_key_event_decoder_if.sv
// Bundles the scancode input, the event FIFO read side and the status outputs
// of the PS/2 key event decoder.
interface ps2_key_event_decoder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_valid;
  logic [7:0]    key_data;
  logic          rd_en;
  logic          evt_valid;
  logic [9:0]    evt_data;
  logic [CW-1:0] evt_count;
  logic [3:0]    held;
  logic          overflow;

  // master feeds bytes and pops events; slave is the decoder
  modport master (
    output key_valid, key_data, rd_en,
    input  evt_valid, evt_data, evt_count, held, overflow
  );

  modport slave (
    input  key_valid, key_data, rd_en,
    output evt_valid, evt_data, evt_count, held, overflow
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// Assembles PS/2 set-2 make/break sequences into key events, tracks held
// direction keys (arrows and WASD) and queues events in a FWFT FIFO.
module ps2_key_event_decoder #(
  parameter int DEPTH           = 8,
  parameter int TIMEOUT_CYCLES  = 2500000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  ps2_key_event_decoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic          emit;
  logic [9:0]    emit_data;

  logic [3:0]    arrow_held, wasd_held;
  logic          dir_hit;
  logic [1:0]    dir_idx;
  logic          suppress, push_req, do_push, do_pop;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A pending prefix is abandoned after a quiet period; an arriving byte wins.
  always_ff @(posedge clock) begin
    if (reset || bus.key_valid || state == IDLE) timer <= '0;
    else                                         timer <= timer + TW'(1);
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_data  = '0;
    if (bus.key_valid) begin
      case (state)
        IDLE: begin
          case (bus.key_data)
            8'hE0: next_state = EXT;
            8'hF0: next_state = BRK;
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: next_state = IDLE;
            default: begin
              emit      = 1'b1;
              emit_data = {2'b00, bus.key_data};
            end
          endcase
        end
        EXT: begin
          case (bus.key_data)
            8'hF0:        next_state = EXT_BRK;
            8'hE0, 8'hE1: next_state = EXT;
            default: begin
              emit       = 1'b1;
              emit_data  = {2'b01, bus.key_data};
              next_state = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          next_state = IDLE;
          if (bus.key_data != 8'hE0 && bus.key_data != 8'hF0) begin
            emit      = 1'b1;
            emit_data = {1'b1, (state == EXT_BRK), bus.key_data};
          end
        end
        default: next_state = IDLE;
      endcase
    end else if (state != IDLE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
      next_state = IDLE;
    end
  end

  always_comb begin
    dir_hit = 1'b1;
    dir_idx = 2'd0;
    case (emit_data[8:0])
      9'h175, 9'h01D: dir_idx = 2'd0;
      9'h16B, 9'h01C: dir_idx = 2'd1;
      9'h172, 9'h01B: dir_idx = 2'd2;
      9'h174, 9'h023: dir_idx = 2'd3;
      default:        dir_hit = 1'b0;
    endcase
  end

  // Typematic repeats of an already-held direction key are not queued.
  assign suppress = (SUPPRESS_REPEAT != 0) && dir_hit && !emit_data[9] &&
                    (emit_data[8] ? arrow_held[dir_idx] : wasd_held[dir_idx]);
  assign push_req = emit && !suppress;
  assign do_pop   = bus.rd_en && (count != '0);
  assign do_push  = push_req && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      arrow_held <= '0;
      wasd_held  <= '0;
    end else if (emit && dir_hit) begin
      if (emit_data[8]) arrow_held[dir_idx] <= !emit_data[9];
      else              wasd_held[dir_idx]  <= !emit_data[9];
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= emit_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !do_push) overflow_q <= 1'b1;
    end
  end

  assign bus.evt_valid = (count != '0);
  assign bus.evt_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.evt_count = count;
  assign bus.held      = arrow_held | wasd_held;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scenario bench for ps2_key_event_decoder: expected events are queued as bytes
// are sent and compared as they are popped from the DUT FIFO.
module tb_ps2_key_event_decoder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_decoder_if #(.DEPTH(DEPTH)) bus ();

  ps2_key_event_decoder #(
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .SUPPRESS_REPEAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.key_valid = 1'b1;
    bus.key_data  = b;
    @(negedge clock);
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Pops every expected event from the DUT, bounded wait on evt_valid.
  task automatic drain(input string name);
    int waited;
    logic [9:0] exp;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (bus.evt_valid !== 1'b1 && waited < 50) begin
        @(negedge clock);
        waited++;
      end
      checks++;
      if (bus.evt_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_wait: evt_valid=%b required 1", name, bus.evt_valid);
        exp_q.delete();
      end else begin
        exp = exp_q.pop_front();
        if (bus.evt_data !== exp) begin
          errors++;
          $display("[TB] FAIL %s_event: got %h required %h", name, bus.evt_data, exp);
        end
        bus.rd_en = 1'b1;
        @(negedge clock);
        bus.rd_en = 1'b0;
      end
    end
    checks++;
    if (bus.evt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_empty: evt_valid=%b required 0", name, bus.evt_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks += 5;
    if (bus.evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", bus.evt_valid); end
    if (bus.evt_data !== 10'h000) begin errors++; $display("[TB] FAIL reset_data: got %h required 000", bus.evt_data); end
    if (bus.evt_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d required 0", bus.evt_count); end
    if (bus.held !== 4'b0000) begin errors++; $display("[TB] FAIL reset_held: got %b required 0000", bus.held); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b required 0", bus.overflow); end
  endtask

  task automatic test_wasd();
    send_byte(8'h1D); exp_q.push_back(10'h01D);
    checks++;
    if (bus.held !== 4'b0001) begin errors++; $display("[TB] FAIL wasd_held_make: got %b required 0001", bus.held); end
    send_byte(8'hF0);
    send_byte(8'h1D); exp_q.push_back(10'h21D);
    checks++;
    if (bus.held !== 4'b0000) begin errors++; $display("[TB] FAIL wasd_held_break: got %b required 0000", bus.held); end
    drain("wasd");
  endtask

  task automatic test_arrow();
    send_byte(8'hE0);
    send_byte(8'h75); exp_q.push_back(10'h175);
    repeat (100) @(negedge clock);
    checks++;
    if (bus.held !== 4'b0001) begin errors++; $display("[TB] FAIL arrow_held_make: got %b required 0001", bus.held); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75); exp_q.push_back(10'h375);
    checks++;
    if (bus.held !== 4'b0000) begin errors++; $display("[TB] FAIL arrow_held_break: got %b required 0000", bus.held); end
    drain("arrow");
  endtask

  task automatic test_repeat();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hE0);
      send_byte(8'h6B);
    end
    exp_q.push_back(10'h16B);
    checks += 2;
    if (bus.held !== 4'b0010) begin errors++; $display("[TB] FAIL repeat_held: got %b required 0010", bus.held); end
    if (bus.evt_count !== 4'd1) begin errors++; $display("[TB] FAIL repeat_count: got %0d required 1", bus.evt_count); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B); exp_q.push_back(10'h36B);
    drain("repeat");
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    send_byte(8'h50); exp_q.push_back(10'h050);
    exp = exp_q.pop_front();
    checks++;
    if (bus.evt_data !== exp) begin errors++; $display("[TB] FAIL b2b_head: got %h required %h", bus.evt_data, exp); end
    bus.key_valid = 1'b1; bus.key_data = 8'h51; bus.rd_en = 1'b1;
    exp_q.push_back(10'h051);
    @(negedge clock);
    bus.key_valid = 1'b0; bus.key_data = 8'h00; bus.rd_en = 1'b0;
    checks++;
    if (bus.evt_count !== 4'd1) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 1", bus.evt_count); end
    drain("b2b");
  endtask

  task automatic test_overflow();
    logic [9:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h40 + 8'(i));
      exp_q.push_back(10'h040 + 10'(i));
    end
    checks += 2;
    if (bus.evt_count !== 4'd8) begin errors++; $display("[TB] FAIL full_count: got %0d required 8", bus.evt_count); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_overflow: got %b required 0", bus.overflow); end
    // push and pop together while full: both happen
    exp = exp_q.pop_front();
    checks++;
    if (bus.evt_data !== exp) begin errors++; $display("[TB] FAIL full_head: got %h required %h", bus.evt_data, exp); end
    @(negedge clock);
    bus.key_valid = 1'b1; bus.key_data = 8'h49; bus.rd_en = 1'b1;
    exp_q.push_back(10'h049);
    @(negedge clock);
    bus.key_valid = 1'b0; bus.key_data = 8'h00; bus.rd_en = 1'b0;
    checks += 2;
    if (bus.evt_count !== 4'd8) begin errors++; $display("[TB] FAIL full_pushpop_count: got %0d required 8", bus.evt_count); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_overflow: got %b required 0", bus.overflow); end
    send_byte(8'h4A);
    checks += 2;
    if (bus.evt_count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_count: got %0d required 8", bus.evt_count); end
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b required 1", bus.overflow); end
    drain("overflow");
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b required 1", bus.overflow); end
  endtask

  task automatic test_timeout();
    // byte lands on the first edge after expiry: prefix forgotten
    send_byte(8'hE0);
    repeat (TIMEOUT - 1) @(negedge clock);
    send_byte(8'h1C); exp_q.push_back(10'h01C);
    checks++;
    if (bus.held !== 4'b0010) begin errors++; $display("[TB] FAIL timeout_held: got %b required 0010", bus.held); end
    send_byte(8'hF0);
    send_byte(8'h1C); exp_q.push_back(10'h21C);
    drain("timeout");
    // byte lands on the expiry edge itself: byte wins, still extended
    send_byte(8'hE0);
    repeat (TIMEOUT - 2) @(negedge clock);
    send_byte(8'h74); exp_q.push_back(10'h174);
    checks++;
    if (bus.held !== 4'b1000) begin errors++; $display("[TB] FAIL expiry_edge_held: got %b required 1000", bus.held); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74); exp_q.push_back(10'h374);
    drain("expiry_edge");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hE0);
    send_byte(8'hF0);
    pulse_reset();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overflow: got %b required 0", bus.overflow); end
    send_byte(8'h74); exp_q.push_back(10'h074);
    checks += 2;
    if (bus.held !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_held: got %b required 0000", bus.held); end
    if (bus.evt_count !== 4'd1) begin errors++; $display("[TB] FAIL midreset_count: got %0d required 1", bus.evt_count); end
    drain("midreset");
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
    bus.rd_en     = 1'b0;
    test_reset();
    test_wasd();
    test_arrow();
    test_repeat();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
